// File: rtl/serial_adder_pkg.sv
// Shared types and sizing helpers for the bit-serial adder.
// Provides the FSM state enum and the bit-counter width function.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_e;

    localparam int unsigned N_DEF = 8;

    // Counter width is ceil(log2(n)); it only has to reach n-1.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    localparam int unsigned CNT_W_DEF = cnt_width(N_DEF);

endpackage

// File: rtl/full_adder_cell.sv
// Single-bit combinational full adder used by the serial datapath.
// Ports: A, B, CIN in; S = A^B^CIN, COUT = majority(A,B,CIN) out.
module full_adder_cell (
    input  logic A,
    input  logic B,
    input  logic CIN,
    output logic S,
    output logic COUT
);

    assign S    = A ^ B ^ CIN;
    assign COUT = (A & B) | (A & CIN) | (B & CIN);

endmodule

// File: rtl/serial_adder_fsm.sv
// Bit-serial N-bit adder: START captures A/B/CIN, one bit per clock
// LSB-first through one full-adder cell; result shown with a DONE pulse.
// Ports: CLK, RST (async, active-high), START, A, B, CIN in;
//        S, COUT, BUSY, DONE out; OVF out when SERIAL_ADDER_OVF_EN.
module serial_adder_fsm
    import serial_adder_pkg::*;
#(
    parameter int unsigned N = N_DEF
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         START,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         CIN,
    output logic [N-1:0] S,
    output logic         COUT,
    output logic         BUSY,
    output logic         DONE
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic         OVF
`endif
);

    localparam int unsigned CW = cnt_width(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    state_e        state_q, state_d;
    logic [N-1:0]  a_q, a_d;
    logic [N-1:0]  b_q, b_d;
    logic [N-1:0]  r_q, r_d;
    logic [N-1:0]  s_q, s_d;
    logic          c_q, c_d;
    logic          co_q, co_d;
    logic          last_q, last_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          fa_s, fa_co;

`ifdef SERIAL_ADDER_OVF_EN
    logic          ovfp_q, ovfp_d;
    logic          ovf_q, ovf_d;
`endif

    full_adder_cell u_fa (
        .A    (a_q[0]),
        .B    (b_q[0]),
        .CIN  (c_q),
        .S    (fa_s),
        .COUT (fa_co)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        r_d     = r_q;
        s_d     = s_q;
        c_d     = c_q;
        co_d    = co_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
`ifdef SERIAL_ADDER_OVF_EN
        ovfp_d  = ovfp_q;
        ovf_d   = ovf_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (START) begin
                    a_d     = A;
                    b_d     = B;
                    c_d     = CIN;
                    cnt_d   = '0;
                    last_d  = 1'b0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (last_q) begin
                    // All bits are in; publish the result.
                    s_d     = r_q;
                    co_d    = c_q;
`ifdef SERIAL_ADDER_OVF_EN
                    ovf_d   = ovfp_q;
`endif
                    state_d = ST_DONE;
                end else begin
                    r_d   = {fa_s, r_q[N-1:1]};
                    c_d   = fa_co;
                    a_d   = a_q >> 1;
                    b_d   = b_q >> 1;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        last_d = 1'b1;
`ifdef SERIAL_ADDER_OVF_EN
                        // Carry into MSB vs carry out of MSB.
                        ovfp_d = c_q ^ fa_co;
`endif
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            r_q     <= '0;
            s_q     <= '0;
            c_q     <= 1'b0;
            co_q    <= 1'b0;
            last_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            r_q     <= r_d;
            s_q     <= s_d;
            c_q     <= c_d;
            co_q    <= co_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef SERIAL_ADDER_OVF_EN
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ovfp_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            ovfp_q <= ovfp_d;
            ovf_q  <= ovf_d;
        end
    end

    assign OVF = ovf_q;
`endif

    assign S    = s_q;
    assign COUT = co_q;
    assign BUSY = (state_q != ST_IDLE);
    assign DONE = (state_q == ST_DONE);

endmodule
